// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter for the shared register-file write port
// ALU and memory writeback producers compete; one registered write issues per cycle.
module wb_port_arbiter #(
  parameter int SW = 21,
  parameter int VW = 192,
  parameter int DW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [DW-1:0] alu_dest,
  input  logic          alu_type,
  input  logic [SW-1:0] alu_scalar,
  input  logic [VW-1:0] alu_vector,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [DW-1:0] mem_dest,
  input  logic          mem_type,
  input  logic [VW-1:0] mem_data,
  input  logic          port_busy,
  output logic          wr_en,
  output logic [DW-1:0] wr_dest,
  output logic          wr_type,
  output logic [SW-1:0] wr_scalar,
  output logic [VW-1:0] wr_vector,
  output logic          wr_src,
  output logic [CW-1:0] conflicts
);

  logic          rr_ptr_q, rr_ptr_d;
  logic          wr_en_q, wr_en_d;
  logic [DW-1:0] wr_dest_q, wr_dest_d;
  logic          wr_type_q, wr_type_d;
  logic [SW-1:0] wr_scalar_q, wr_scalar_d;
  logic [VW-1:0] wr_vector_q, wr_vector_d;
  logic          wr_src_q, wr_src_d;
  logic [CW-1:0] conflicts_q, conflicts_d;
  logic          grant_alu, grant_mem;

  always_comb begin
    grant_alu   = 1'b0;
    grant_mem   = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    wr_en_d     = 1'b0;
    wr_dest_d   = wr_dest_q;
    wr_type_d   = wr_type_q;
    wr_scalar_d = wr_scalar_q;
    wr_vector_d = wr_vector_q;
    wr_src_d    = wr_src_q;
    conflicts_d = conflicts_q;

    // Ready is gated by reset so neither producer sees a grant while held in reset.
    if (rst_n && !port_busy) begin
      if (alu_valid && (!mem_valid || !rr_ptr_q)) begin
        grant_alu = 1'b1;
      end else if (mem_valid) begin
        grant_mem = 1'b1;
      end
    end

    if (grant_alu) begin
      wr_en_d     = 1'b1;
      wr_dest_d   = alu_dest;
      wr_type_d   = alu_type;
      wr_scalar_d = alu_scalar;
      wr_vector_d = alu_vector;
      wr_src_d    = 1'b0;
      rr_ptr_d    = 1'b1;
    end else if (grant_mem) begin
      wr_en_d     = 1'b1;
      wr_dest_d   = mem_dest;
      wr_type_d   = mem_type;
      wr_scalar_d = mem_data[SW-1:0];
      wr_vector_d = mem_data;
      wr_src_d    = 1'b1;
      rr_ptr_d    = 1'b0;
    end

    if (alu_valid && mem_valid && !port_busy && !(&conflicts_q)) begin
      conflicts_d = conflicts_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_dest_q   <= '0;
      wr_type_q   <= 1'b0;
      wr_scalar_q <= '0;
      wr_vector_q <= '0;
      wr_src_q    <= 1'b0;
      conflicts_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_dest_q   <= wr_dest_d;
      wr_type_q   <= wr_type_d;
      wr_scalar_q <= wr_scalar_d;
      wr_vector_q <= wr_vector_d;
      wr_src_q    <= wr_src_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;
  assign wr_en     = wr_en_q;
  assign wr_dest   = wr_dest_q;
  assign wr_type   = wr_type_q;
  assign wr_scalar = wr_scalar_q;
  assign wr_vector = wr_vector_q;
  assign wr_src    = wr_src_q;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
// Directed table, saturation and reset sequences plus random traffic against a reference model.
module tb_wb_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         alu_valid, alu_type, mem_valid, mem_type, port_busy;
  logic [3:0]   alu_dest, mem_dest;
  logic [20:0]  alu_scalar;
  logic [191:0] alu_vector, mem_data;
  logic         alu_ready, mem_ready, wr_en, wr_type, wr_src;
  logic [3:0]   wr_dest;
  logic [20:0]  wr_scalar;
  logic [191:0] wr_vector;
  logic [15:0]  conflicts;
  logic         s_alu_ready, s_mem_ready, s_wr_en, s_wr_type, s_wr_src;
  logic [3:0]   s_wr_dest;
  logic [20:0]  s_wr_scalar;
  logic [191:0] s_wr_vector;
  logic [3:0]   s_conflicts;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_type(alu_type),
    .alu_scalar(alu_scalar), .alu_vector(alu_vector),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_type(mem_type),
    .mem_data(mem_data), .port_busy(port_busy),
    .wr_en(wr_en), .wr_dest(wr_dest), .wr_type(wr_type), .wr_scalar(wr_scalar),
    .wr_vector(wr_vector), .wr_src(wr_src), .conflicts(conflicts)
  );

  wb_port_arbiter #(.CW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(s_alu_ready), .alu_dest(alu_dest), .alu_type(alu_type),
    .alu_scalar(alu_scalar), .alu_vector(alu_vector),
    .mem_valid(mem_valid), .mem_ready(s_mem_ready), .mem_dest(mem_dest), .mem_type(mem_type),
    .mem_data(mem_data), .port_busy(port_busy),
    .wr_en(s_wr_en), .wr_dest(s_wr_dest), .wr_type(s_wr_type), .wr_scalar(s_wr_scalar),
    .wr_vector(s_wr_vector), .wr_src(s_wr_src), .conflicts(s_conflicts)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: who wrote last, what the file should see next, how many conflicts so far.
  int           m_last;
  logic         m_wr_en, m_type, m_src;
  logic [3:0]   m_dest;
  logic [20:0]  m_scalar;
  logic [191:0] m_vector;
  int           m_conf;
  logic         got_alu, got_mem;

  function automatic int pick(input logic a, input logic m, input logic busy, input logic rst);
    if (!rst || busy) return -1;
    if (a && m) return (m_last == 0) ? 1 : 0;
    if (a) return 0;
    if (m) return 1;
    return -1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_last = 1; m_wr_en = 0; m_type = 0; m_src = 0; m_dest = 0;
    m_scalar = 0; m_vector = 0; m_conf = 0;
  endtask

  task automatic cycle();
    int w;
    w = pick(alu_valid, mem_valid, port_busy, rst_n);
    #1;
    got_alu = alu_ready;
    got_mem = mem_ready;
    chk("alu_ready", {191'h0, alu_ready}, {191'h0, w == 0});
    chk("mem_ready", {191'h0, mem_ready}, {191'h0, w == 1});
    chk("sat_ready", {190'h0, s_alu_ready, s_mem_ready}, {190'h0, w == 0, w == 1});
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_wr_en = (w >= 0);
      if (w == 0) begin
        m_dest = alu_dest; m_type = alu_type; m_scalar = alu_scalar; m_vector = alu_vector; m_src = 0;
      end else if (w == 1) begin
        m_dest = mem_dest; m_type = mem_type; m_scalar = mem_data[20:0]; m_vector = mem_data; m_src = 1;
      end
      if (w >= 0) m_last = w;
      if (alu_valid && mem_valid && !port_busy) m_conf++;
    end
    #1;
    chk("wr_en", {191'h0, wr_en}, {191'h0, m_wr_en});
    chk("wr_dest", {188'h0, wr_dest}, {188'h0, m_dest});
    chk("wr_type", {191'h0, wr_type}, {191'h0, m_type});
    chk("wr_scalar", {171'h0, wr_scalar}, {171'h0, m_scalar});
    chk("wr_vector", wr_vector, m_vector);
    chk("wr_src", {191'h0, wr_src}, {191'h0, m_src});
    chk("conflicts", {176'h0, conflicts}, 192'(sat(m_conf, 65535)));
    chk("conflicts_sat", {188'h0, s_conflicts}, 192'(sat(m_conf, 15)));
  endtask

  typedef struct {
    logic av; logic [3:0] ad; logic at; logic [20:0] as; logic [191:0] avec;
    logic mv; logic [3:0] md; logic mt; logic [191:0] mdat; logic busy;
    logic e_ar; logic e_mr; logic e_wen; logic e_src; logic [3:0] e_dest;
    logic [20:0] e_sc; logic [15:0] e_conf;
  } vec_t;

  localparam logic [191:0] AVEC = {8{24'h3C3C3C}};
  localparam logic [191:0] MVEC = {8{24'hA5A5A5}};
  vec_t tbl[13];

  function automatic logic [191:0] rnd192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 4'h3, 1'b0, 21'h1ABCD, 192'h0, 1'b0, 4'h0, 1'b0, 192'h0, 1'b0,
                1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 21'h1ABCD, 16'd0};
    tbl[1]  = '{1'b0, 4'h0, 1'b0, 21'h0, 192'h0, 1'b0, 4'h0, 1'b0, 192'h0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 21'h1ABCD, 16'd0};
    tbl[2]  = '{1'b0, 4'h0, 1'b0, 21'h0, 192'h0, 1'b1, 4'h5, 1'b0, 192'h12345, 1'b0,
                1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 21'h12345, 16'd0};
    tbl[3]  = '{1'b1, 4'h1, 1'b1, 21'h00111, AVEC, 1'b1, 4'h2, 1'b1, MVEC, 1'b0,
                1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 21'h00111, 16'd1};
    tbl[4]  = '{1'b1, 4'h1, 1'b1, 21'h00111, AVEC, 1'b1, 4'h2, 1'b1, MVEC, 1'b0,
                1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 21'h05A5A5, 16'd2};
    tbl[5]  = '{1'b1, 4'h1, 1'b1, 21'h00111, AVEC, 1'b1, 4'h2, 1'b1, MVEC, 1'b0,
                1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 21'h00111, 16'd3};
    tbl[6]  = '{1'b1, 4'h1, 1'b1, 21'h00111, AVEC, 1'b1, 4'h2, 1'b1, MVEC, 1'b0,
                1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 21'h05A5A5, 16'd4};
    for (int i = 7; i <= 9; i++)
      tbl[i] = '{1'b1, 4'h1, 1'b1, 21'h00111, AVEC, 1'b1, 4'h2, 1'b1, MVEC, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 21'h05A5A5, 16'd4};
    tbl[10] = '{1'b1, 4'h1, 1'b1, 21'h00111, AVEC, 1'b1, 4'h2, 1'b1, MVEC, 1'b0,
                1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 21'h00111, 16'd5};
    tbl[11] = '{1'b0, 4'h0, 1'b0, 21'h0, 192'h0, 1'b1, 4'hF, 1'b0, {171'h0, 21'h0F00F}, 1'b0,
                1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 21'h0F00F, 16'd5};
    tbl[12] = '{1'b0, 4'h0, 1'b0, 21'h0, 192'h0, 1'b0, 4'h0, 1'b0, 192'h0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 21'h0F00F, 16'd5};

    rst_n = 0; alu_valid = 0; alu_type = 0; alu_dest = 0; alu_scalar = 0; alu_vector = 0;
    mem_valid = 0; mem_type = 0; mem_dest = 0; mem_data = 0; port_busy = 0;
    model_reset();
    @(negedge clk);
    cycle();
    chk("reset_wr_en", {191'h0, wr_en}, 192'h0);
    chk("reset_conflicts", {176'h0, conflicts}, 192'h0);

    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      alu_valid = tbl[i].av; alu_dest = tbl[i].ad; alu_type = tbl[i].at;
      alu_scalar = tbl[i].as; alu_vector = tbl[i].avec;
      mem_valid = tbl[i].mv; mem_dest = tbl[i].md; mem_type = tbl[i].mt;
      mem_data = tbl[i].mdat; port_busy = tbl[i].busy;
      cycle();
      chk($sformatf("t%0d_alu_ready", i), {191'h0, got_alu}, {191'h0, tbl[i].e_ar});
      chk($sformatf("t%0d_mem_ready", i), {191'h0, got_mem}, {191'h0, tbl[i].e_mr});
      chk($sformatf("t%0d_wr_en", i), {191'h0, wr_en}, {191'h0, tbl[i].e_wen});
      chk($sformatf("t%0d_wr_src", i), {191'h0, wr_src}, {191'h0, tbl[i].e_src});
      chk($sformatf("t%0d_wr_dest", i), {188'h0, wr_dest}, {188'h0, tbl[i].e_dest});
      chk($sformatf("t%0d_wr_scalar", i), {171'h0, wr_scalar}, {171'h0, tbl[i].e_sc});
      chk($sformatf("t%0d_conflicts", i), {176'h0, conflicts}, {176'h0, tbl[i].e_conf});
    end

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      alu_valid = 1; mem_valid = 1; port_busy = 0;
      cycle();
    end
    chk("sat_conflicts_cw4", {188'h0, s_conflicts}, 192'hF);
    chk("sat_conflicts_cw16", {176'h0, conflicts}, 192'd25);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!alu_valid || got_alu) begin
        alu_valid = 1'($urandom_range(0, 1)); alu_dest = 4'($urandom); alu_type = 1'($urandom);
        alu_scalar = 21'($urandom); alu_vector = rnd192();
      end
      if (!mem_valid || got_mem) begin
        mem_valid = 1'($urandom_range(0, 1)); mem_dest = 4'($urandom); mem_type = 1'($urandom);
        mem_data = rnd192();
      end
      port_busy = ($urandom_range(0, 3) == 0);
      cycle();
    end

    @(negedge clk);
    alu_valid = 1; mem_valid = 1; port_busy = 0;
    cycle();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_wr_en", {191'h0, wr_en}, 192'h0);
    chk("rst_mid_conflicts", {176'h0, conflicts}, 192'h0);
    chk("rst_mid_ready", {190'h0, alu_ready, mem_ready}, 192'h0);
    model_reset();
    @(negedge clk);
    cycle();
    @(negedge clk);
    rst_n = 1;
    cycle();
    chk("rst_first_grant_alu", {191'h0, got_alu}, 192'h1);
    chk("rst_first_src_alu", {191'h0, wr_src}, 192'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
